// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            invalid_instruction
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg_q;

    logic              accept;
    logic              sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

`ifdef MULDIV_DIV_EN
    logic              neg_r;
    logic [XLEN:0]     rem_sh, diff;
    logic              qbit;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quot, rem, div_res;
    logic              div0, ovf;

    assign invalid_instruction = 1'b0;
`else
    assign invalid_instruction = valid_in & funct3[2];
`endif

    assign accept = (state == S_IDLE) & valid_in & ~flush & ~invalid_instruction;
    assign busy   = (state == S_MUL) | (state == S_DIV);
    assign done   = (state == S_DONE);
    assign stall  = accept | busy;

    always_comb begin
        // Divides sign both operands unless unsigned; MULH both, MULHSU rs1 only
        sgn1 = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        sgn2 = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
        neg1 = sgn1 & rs1_val[XLEN-1];
        neg2 = sgn2 & rs2_val[XLEN-1];
        mag1 = neg1 ? -rs1_val : rs1_val;
        mag2 = neg2 ? -rs2_val : rs2_val;
    end

    // acc = {partial product high half, remaining multiplier bits}, shifted right each step
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        prod     = neg_q ? -mul_next : mul_next;
        mul_res  = (op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    always_comb begin
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, opnd};
        qbit     = ~diff[XLEN];
        div_next = {(qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], qbit};
        quot     = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        div_res  = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quot : quot);
        div0     = (rs2_val == '0);
        ovf      = ~funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            op     <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            result <= '0;
`ifdef MULDIV_DIV_EN
            neg_r  <= 1'b0;
`endif
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op    <= funct3;
                        acc   <= {{XLEN{1'b0}}, mag1};
                        opnd  <= mag2;
                        neg_q <= neg1 ^ neg2;
                        count <= CW'(XLEN);
`ifdef MULDIV_DIV_EN
                        neg_r <= neg1;
                        if (funct3[2]) begin
                            if (div0) begin
                                result <= funct3[1] ? rs1_val : '1;
                                state  <= S_DONE;
                            end else if (ovf) begin
                                result <= funct3[1] ? '0 : rs1_val;
                                state  <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
                            state <= S_MUL;
                        end
`else
                        state <= S_MUL;
`endif
                    end
                end
                S_MUL: begin
                    acc   <= mul_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result <= mul_res;
                        state  <= S_DONE;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    acc   <= div_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        result <= div_res;
                        state  <= S_DONE;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
